// File: rtl/accum_pkg.sv
// Shared types for the accumulator stream writer: FSM state encoding and the
// latched burst descriptor.
package accum_pkg;

  localparam int ACCUM_BANKS  = 4;
  localparam int ACCUM_ADDR_W = 9;
  localparam int ACCUM_DATA_W = 64;
  localparam int ACCUM_ZONE_W = 2;
  localparam int ACCUM_LEN_W  = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } accum_wr_state_e;

  // The addr field doubles as the running word pointer once the burst starts.
  typedef struct packed {
    logic [ACCUM_ZONE_W-1:0] zone;
    logic [ACCUM_ADDR_W-1:0] addr;
    logic [ACCUM_LEN_W-1:0]  len;
    logic [ACCUM_BANKS-1:0]  mask;
    logic                    accum;
  } accum_wr_desc_t;

endpackage

// File: rtl/accum_stream_writer_if.sv
// Command and data channel interfaces of the accumulator subsystem slave
// ports; the writer drives the Master side of both.
interface Accum_Cmd_If
  import accum_pkg::*;
#(
  parameter int NUM_BANKS  = ACCUM_BANKS,
  parameter int ADDR_WIDTH = ACCUM_ADDR_W,
  parameter int ZONE_WIDTH = ACCUM_ZONE_W
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ZONE_WIDTH-1:0] wr_zone_id;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_BANKS-1:0]  wr_mask;
  logic                  accum_en;
  logic                  rd_valid;
  logic [ZONE_WIDTH-1:0] rd_zone_id;
  logic [ADDR_WIDTH-1:0] rd_addr;

  modport Master (
    output wr_valid, wr_zone_id, wr_addr, wr_mask, accum_en,
    output rd_valid, rd_zone_id, rd_addr,
    input  wr_ready
  );
  modport Slave (
    input  wr_valid, wr_zone_id, wr_addr, wr_mask, accum_en,
    input  rd_valid, rd_zone_id, rd_addr,
    output wr_ready
  );
endinterface

interface Accum_Data_If
  import accum_pkg::*;
#(
  parameter int DATA_WIDTH = ACCUM_DATA_W
);
  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport Master (output wvalid, wdata, input wready, rvalid, rdata);
  modport Slave  (input wvalid, wdata, output wready, rvalid, rdata);
endinterface

// File: rtl/accum_beat_buffer.sv
// One-entry beat buffer. Each channel keeps its own pending flag (a cleared
// flag on a full buffer means that channel's beat was already sent).
module accum_beat_buffer
  import accum_pkg::*;
#(
  parameter int DATA_WIDTH = ACCUM_DATA_W
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  cmd_ready,
  input  logic                  data_ready,
  output logic                  cmd_valid,
  output logic                  data_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  retire
);

  assign empty  = !cmd_valid && !data_valid;
  assign retire = !empty && (!cmd_valid || cmd_ready) && (!data_valid || data_ready);

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd_valid  <= 1'b0;
      data_valid <= 1'b0;
      // NOTE: the data register is reset only because the payload must read zero out of reset.
      dout       <= '0;
    end else if (load) begin
      cmd_valid  <= 1'b1;
      data_valid <= 1'b1;
      dout       <= din;
    end else begin
      if (cmd_valid && cmd_ready)   cmd_valid  <= 1'b0;
      if (data_valid && data_ready) data_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/accum_stream_writer.sv
// Burst write master: one descriptor plus a word stream becomes one cmd/data
// beat pair per word. Define ACCUM_STREAM_WRITER_PERF_EN to add perf_stall_cnt.
module accum_stream_writer
  import accum_pkg::*;
#(
  parameter int NUM_BANKS  = ACCUM_BANKS,
  parameter int ADDR_WIDTH = ACCUM_ADDR_W,
  parameter int DATA_WIDTH = ACCUM_DATA_W,
  parameter int ZONE_WIDTH = ACCUM_ZONE_W,
  parameter int LEN_WIDTH  = ACCUM_LEN_W
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [ZONE_WIDTH-1:0] desc_zone,
  input  logic [ADDR_WIDTH-1:0] desc_addr,
  input  logic [LEN_WIDTH-1:0]  desc_len,
  input  logic [NUM_BANKS-1:0]  desc_mask,
  input  logic                  desc_accum,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  busy,
  output logic                  done,
  Accum_Cmd_If.Master           m_cmd,
  Accum_Data_If.Master          m_data
`ifdef ACCUM_STREAM_WRITER_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt
`endif
);

  accum_wr_state_e      state, state_nxt;
  accum_wr_desc_t       d_q;
  logic [LEN_WIDTH-1:0] load_cnt, beat_cnt;
  logic                 desc_fire, buf_load, buf_retire, buf_empty, last_beat;

  assign desc_ready = (state == IDLE);
  assign desc_fire  = desc_valid && desc_ready;
  assign s_ready    = (state == RUN) && (buf_empty || buf_retire) && (load_cnt < d_q.len);
  assign buf_load   = s_valid && s_ready;
  assign last_beat  = buf_retire && ((beat_cnt + LEN_WIDTH'(1)) == d_q.len);

  accum_beat_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk        (clk),
    .rstn       (rstn),
    .load       (buf_load),
    .din        (s_data),
    .cmd_ready  (m_cmd.wr_ready),
    .data_ready (m_data.wready),
    .cmd_valid  (m_cmd.wr_valid),
    .data_valid (m_data.wvalid),
    .dout       (m_data.wdata),
    .empty      (buf_empty),
    .retire     (buf_retire)
  );

  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE:    if (desc_fire) state_nxt = (desc_len != '0) ? RUN : DONE;
      RUN:     if (last_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      d_q      <= '0;
      load_cnt <= '0;
      beat_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == DONE);
      if (desc_fire) begin
        d_q      <= '{zone: desc_zone, addr: desc_addr, len: desc_len,
                      mask: desc_mask, accum: desc_accum};
        load_cnt <= '0;
        beat_cnt <= '0;
      end else begin
        if (buf_load) load_cnt <= load_cnt + LEN_WIDTH'(1);
        // Pointer wraps naturally at 2^ADDR_WIDTH.
        if (buf_retire) begin
          d_q.addr <= d_q.addr + ADDR_WIDTH'(1);
          beat_cnt <= beat_cnt + LEN_WIDTH'(1);
        end
      end
    end
  end

  assign m_cmd.wr_zone_id = d_q.zone;
  assign m_cmd.wr_addr    = d_q.addr;
  assign m_cmd.wr_mask    = d_q.mask;
  assign m_cmd.accum_en   = d_q.accum;
  assign m_cmd.rd_valid   = 1'b0;
  assign m_cmd.rd_zone_id = '0;
  assign m_cmd.rd_addr    = '0;

  logic unused_rd;
  assign unused_rd = ^{m_data.rvalid, m_data.rdata};

`ifdef ACCUM_STREAM_WRITER_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_stall_cnt <= '0;
    end else if (desc_fire) begin
      perf_stall_cnt <= '0;
    end else if ((state == RUN) && !buf_empty && !buf_retire && (perf_stall_cnt != '1)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_accum_stream_writer.sv
// Bench for accum_stream_writer: directed scenarios plus randomized bursts
// checked against a descriptor-level model of the expected beat sequence.
module tb_accum_stream_writer;
  import accum_pkg::*;

  localparam int NB = 4;
  localparam int AW = 9;
  localparam int DW = 64;
  localparam int ZW = 2;
  localparam int LW = 10;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          desc_valid = 1'b0, desc_accum = 1'b0, desc_ready;
  logic [ZW-1:0] desc_zone  = '0;
  logic [AW-1:0] desc_addr  = '0;
  logic [LW-1:0] desc_len   = '0;
  logic [NB-1:0] desc_mask  = '0;
  logic          s_valid, s_ready, busy, done;
  logic [DW-1:0] s_data;
`ifdef ACCUM_STREAM_WRITER_PERF_EN
  logic [31:0]   perf_stall_cnt;
`endif

  Accum_Cmd_If  #(.NUM_BANKS(NB), .ADDR_WIDTH(AW), .ZONE_WIDTH(ZW)) cmd_if ();
  Accum_Data_If #(.DATA_WIDTH(DW)) data_if ();

  accum_stream_writer #(
    .NUM_BANKS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ZONE_WIDTH(ZW), .LEN_WIDTH(LW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .desc_valid (desc_valid),
    .desc_ready (desc_ready),
    .desc_zone  (desc_zone),
    .desc_addr  (desc_addr),
    .desc_len   (desc_len),
    .desc_mask  (desc_mask),
    .desc_accum (desc_accum),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .busy       (busy),
    .done       (done),
    .m_cmd      (cmd_if),
    .m_data     (data_if)
`ifdef ACCUM_STREAM_WRITER_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [ZW-1:0] zone;
    logic [NB-1:0] mask;
    logic          accum;
    longint        stamp;
  } cmd_obs_t;

  typedef struct {
    logic [DW-1:0] data;
    longint        stamp;
  } dat_obs_t;

  int            compared = 0, mismatched = 0;
  longint        cyc = 0;
  cmd_obs_t      cmd_q[$];
  dat_obs_t      dat_q[$];
  logic [DW-1:0] stream_q[$];
  logic [DW-1:0] words[$];
  int            done_cnt = 0, valid_cycles = 0;
  longint        done_stamp = 0, desc_stamp = 0;
  bit            s_acc = 1'b0, rand_ready = 1'b0;
  int            s_gap_pct = 0;
  logic          prev_cmd_stall = 1'b0, prev_dat_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_wdata = '0;

  logic [ZW-1:0] cur_zone;
  logic [AW-1:0] cur_addr;
  int            cur_len;
  logic [NB-1:0] cur_mask;
  logic          cur_accum;
  int            done0, vc0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Observer: sampled on the falling edge, handshakes complete on the next rising edge.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_cmd_stall = 1'b0;
      prev_dat_stall = 1'b0;
      s_acc          = 1'b0;
    end else begin
      if (prev_cmd_stall) begin
        check("cmd_hold_valid", cmd_if.wr_valid, 1);
        check("cmd_hold_addr", cmd_if.wr_addr, prev_addr);
      end
      if (prev_dat_stall) begin
        check("data_hold_valid", data_if.wvalid, 1);
        check("data_hold_wdata", data_if.wdata, prev_wdata);
      end
      prev_cmd_stall = cmd_if.wr_valid && !cmd_if.wr_ready;
      prev_dat_stall = data_if.wvalid && !data_if.wready;
      prev_addr      = cmd_if.wr_addr;
      prev_wdata     = data_if.wdata;
      if (cmd_if.wr_valid && cmd_if.wr_ready)
        cmd_q.push_back('{cmd_if.wr_addr, cmd_if.wr_zone_id, cmd_if.wr_mask, cmd_if.accum_en, cyc});
      if (data_if.wvalid && data_if.wready)
        dat_q.push_back('{data_if.wdata, cyc});
      if (cmd_if.wr_valid || data_if.wvalid) valid_cycles++;
      if (done) begin
        done_cnt++;
        done_stamp = cyc;
      end
      if (desc_valid && desc_ready) desc_stamp = cyc;
      s_acc = s_valid && s_ready;
    end
  end

  // Stream source: presents stream_q in order, optionally with random gaps.
  initial begin
    s_valid = 1'b0;
    s_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (s_acc && stream_q.size() > 0) void'(stream_q.pop_front());
      if (stream_q.size() > 0 && $urandom_range(99) >= s_gap_pct) begin
        s_valid = 1'b1;
        s_data  = stream_q[0];
      end else begin
        s_valid = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) begin
        cmd_if.wr_ready = ($urandom_range(3) != 0);
        data_if.wready  = ($urandom_range(3) != 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic drive_edge();
    @(posedge clk); #1;
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back({$urandom, $urandom});
  endtask

  task automatic poll(input int what, input int n, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if ((what == 0 && data_if.wvalid) || (what == 1 && cmd_if.wr_valid) ||
          (what == 2 && cmd_q.size() >= n)) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, ok, 1);
  endtask

  // Caller fills words with at least len+2 entries; the extras must never be taken.
  task automatic start_burst(input logic [ZW-1:0] z, input logic [AW-1:0] a, input int l,
                             input logic [NB-1:0] m, input logic acc);
    bit ok = 1'b0;
    cur_zone = z; cur_addr = a; cur_len = l; cur_mask = m; cur_accum = acc;
    cmd_q.delete();
    dat_q.delete();
    stream_q.delete();
    for (int i = 0; i < l + 2; i++) stream_q.push_back(words[i]);
    done0 = done_cnt;
    vc0   = valid_cycles;
    drive_edge();
    desc_valid = 1'b1; desc_zone = z; desc_addr = a; desc_len = LW'(l);
    desc_mask  = m;    desc_accum = acc;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (desc_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("desc_accept", ok, 1);
    drive_edge();
    desc_valid = 1'b0;
  endtask

  task automatic finish_burst();
    bit     ok = 1'b0;
    longint last;
    for (int i = 0; i < 20 * cur_len + 200; i++) begin
      step();
      if (done_cnt > done0) begin
        ok = 1'b1;
        break;
      end
    end
    check("done_seen", ok, 1);
    check("desc_ready_in_done", desc_ready, 0);
    check("busy_in_done", busy, 1);
    step();
    check("done_one_cycle", done_cnt, done0 + 1);
    check("desc_ready_after_done", desc_ready, 1);
    check("busy_after_done", busy, 0);
    check("cmd_count", cmd_q.size(), cur_len);
    check("data_count", dat_q.size(), cur_len);
    check("extra_words_untouched", stream_q.size(), 2);
    for (int i = 0; i < cmd_q.size() && i < cur_len; i++) begin
      check("cmd_addr", cmd_q[i].addr, (int'(cur_addr) + i) % (1 << AW));
      check("cmd_zone", cmd_q[i].zone, cur_zone);
      check("cmd_mask", cmd_q[i].mask, cur_mask);
      check("cmd_accum", cmd_q[i].accum, cur_accum);
    end
    for (int i = 0; i < dat_q.size() && i < cur_len; i++)
      check("wdata", dat_q[i].data, words[i]);
    if (cur_len == 0) begin
      check("len0_done_latency", done_stamp, desc_stamp + 1);
      check("len0_no_traffic", valid_cycles, vc0);
    end else if (ok && cmd_q.size() == cur_len && dat_q.size() == cur_len) begin
      last = (cmd_q[$].stamp > dat_q[$].stamp) ? cmd_q[$].stamp : dat_q[$].stamp;
      check("done_latency", done_stamp, last + 1);
    end
    stream_q.delete();
  endtask

  initial begin
    data_if.rvalid  = 1'b0;
    data_if.rdata   = '0;
    cmd_if.wr_ready = 1'b1;
    data_if.wready  = 1'b1;

    // Reset state.
    step();
    check("rst_desc_ready", desc_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_wr_valid", cmd_if.wr_valid, 0);
    check("rst_wvalid", data_if.wvalid, 0);
    check("rst_rd_valid", cmd_if.rd_valid, 0);
    check("rst_wr_addr", cmd_if.wr_addr, 0);
    check("rst_wr_zone", cmd_if.wr_zone_id, 0);
    check("rst_wr_mask", cmd_if.wr_mask, 0);
    check("rst_accum_en", cmd_if.accum_en, 0);
    check("rst_wdata", data_if.wdata, 0);
    check("rst_rd_addr", cmd_if.rd_addr, 0);
    drive_edge();
    rstn = 1'b1;
    step();
    check("idle_s_ready", s_ready, 0);

    // Full-rate burst of four.
    words = '{64'hA0, 64'hA1, 64'hA2, 64'hA3, 64'hB0, 64'hB1};
    start_burst(2'd2, 9'h010, 4, 4'b1111, 1'b1);
    finish_burst();
    if (cmd_q.size() == 4) begin
      check("first_beat_latency", cmd_q[0].stamp, desc_stamp + 2);
      for (int i = 1; i < 4; i++) check("back_to_back", cmd_q[i].stamp, cmd_q[0].stamp + i);
    end

    // Data channel stalls while the cmd channel is ready.
    data_if.wready = 1'b0;
    start_burst(2'd2, 9'h010, 4, 4'b1111, 1'b1);
    poll(0, 0, "t2_wvalid_seen");
    check("t2_sready_full", s_ready, 0);
    check("t2_cmd_valid", cmd_if.wr_valid, 1);
    for (int k = 0; k < 2; k++) begin
      drive_edge();
      step();
      check("t2_cmd_dropped", cmd_if.wr_valid, 0);
      check("t2_data_held", data_if.wvalid, 1);
      check("t2_sready_blocked", s_ready, 0);
      check("t2_single_cmd", cmd_q.size(), 1);
    end
    drive_edge();
    data_if.wready = 1'b1;
    step();
    check("t2_sready_on_retire", s_ready, 1);
    check("t2_cmd_still_sent", cmd_if.wr_valid, 0);
    finish_burst();

    // Address wrap at the top of the address space.
    rand_words(6);
    start_burst(2'd1, 9'h1FE, 4, 4'b0101, 1'b0);
    finish_burst();

    // Zero-length descriptor.
    rand_words(2);
    start_burst(2'd3, 9'h0A5, 0, 4'b1000, 1'b1);
    finish_burst();

    // Asynchronous reset in the middle of an eight-beat burst.
    rand_words(10);
    start_burst(2'd0, 9'h100, 8, 4'b0011, 1'b1);
    poll(2, 2, "t5_two_beats_sent");
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    check("t5_wr_valid_async", cmd_if.wr_valid, 0);
    check("t5_wvalid_async", data_if.wvalid, 0);
    check("t5_s_ready_async", s_ready, 0);
    check("t5_busy_async", busy, 0);
    check("t5_desc_ready_async", desc_ready, 1);
    check("t5_wr_addr_async", cmd_if.wr_addr, 0);
    step();
    stream_q.delete();
    step();
    drive_edge();
    rstn = 1'b1;
    repeat (3) step();
    check("t5_no_done", done_cnt, done0);
    rand_words(7);
    start_burst(2'd2, 9'h033, 5, 4'b1110, 1'b0);
    finish_burst();

`ifdef ACCUM_STREAM_WRITER_PERF_EN
    // Stall counter: cmd channel held off for five cycles on the first beat.
    cmd_if.wr_ready = 1'b0;
    rand_words(4);
    start_burst(2'd1, 9'h040, 2, 4'b1111, 1'b1);
    poll(1, 0, "t6_wr_valid_seen");
    repeat (5) drive_edge();
    cmd_if.wr_ready = 1'b1;
    finish_burst();
    check("t6_perf_stall_cnt", perf_stall_cnt, 5);
    rand_words(5);
    start_burst(2'd0, 9'h050, 3, 4'b0001, 1'b0);
    finish_burst();
    check("t6_perf_cleared", perf_stall_cnt, 0);
`endif

    // Randomized bursts with random readies and stream gaps.
    rand_ready = 1'b1;
    s_gap_pct  = 30;
    for (int n = 0; n < 20; n++) begin
      int l;
      l = $urandom_range(12);
      rand_words(l + 2);
      start_burst(ZW'($urandom_range(3)),
                  ($urandom_range(3) == 0) ? AW'(504 + $urandom_range(7)) : AW'($urandom_range(511)),
                  l, NB'($urandom_range(15)), 1'($urandom_range(1)));
      finish_burst();
    end
    rand_ready      = 1'b0;
    s_gap_pct       = 0;
    cmd_if.wr_ready = 1'b1;
    data_if.wready  = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
